rca4_sweep_checker: RTL and testbench

Self-checking exhaustive sweep engine for 4-bit adders under test (accurate or approximate RCA variants). On `start` it drives all 512 {A, B, Cin} combinations to an external adder and reads back its Sum/Cout. It compares each result against an internal exact reference and accumulates error metrics: error count, summed error distance, maximum error distance and the first failing vector. It is the consuming end of the adder's operand/result interface, used in silicon and simulation characterisation of approximate adders.

---
 rtl/rca4_sweep_checker.sv | 121 ++++++++++++
 tb/tb_rca4_sweep_checker.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca4_sweep_checker.sv
// rca4_sweep_checker: drives all 512 {A,B,Cin} vectors to an external 4-bit adder and scores its results.
// Define SWEEP_FIRST_ERR_EN to build capture of the first mismatching vector.
module rca4_sweep_checker #(
    parameter int unsigned LAT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  A_out,
    output logic [3:0]  B_out,
    output logic        Cin_out,
    input  logic [3:0]  dut_sum,
    input  logic        dut_cout,
    output logic        busy,
    output logic        done,
    output logic [9:0]  err_cnt,
    output logic [13:0] sed,
    output logic [4:0]  max_ed,
    output logic [8:0]  first_err_vec,
    output logic        first_err_valid
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] LAT_LAST = 2'(LAT_CYC - 1);

    state_t     state;
    logic [8:0] idx;
    logic [1:0] lat_cnt;
    logic [4:0] exact_val;
    logic [4:0] dut_val;
    logic [4:0] ed;
    logic       sample;

    // The index register is the operand bus, so the operands are registered for free.
    assign A_out   = idx[8:5];
    assign B_out   = idx[4:1];
    assign Cin_out = idx[0];

    always_comb begin
        exact_val = {1'b0, idx[8:5]} + {1'b0, idx[4:1]} + {4'b0000, idx[0]};
        dut_val   = {dut_cout, dut_sum};
        ed        = (exact_val >= dut_val) ? (exact_val - dut_val) : (dut_val - exact_val);
        sample    = (state == RUN) && (lat_cnt == LAT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            lat_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err_cnt <= '0;
            sed     <= '0;
            max_ed  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        idx     <= '0;
                        lat_cnt <= '0;
                        busy    <= 1'b1;
                        err_cnt <= '0;
                        sed     <= '0;
                        max_ed  <= '0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        lat_cnt <= '0;
                        if (ed != '0) begin
                            err_cnt <= err_cnt + 10'd1;
                            sed     <= sed + 14'(ed);
                            if (ed > max_ed) begin
                                max_ed <= ed;
                            end
                        end
                        if (idx == '1) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + 9'd1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SWEEP_FIRST_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if ((state == IDLE) && start) begin
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if (sample && (ed != '0) && !first_err_valid) begin
            first_err_vec   <= idx;
            first_err_valid <= 1'b1;
        end
    end
`else
    assign first_err_vec   = '0;
    assign first_err_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rca4_sweep_checker.sv
// Bench for rca4_sweep_checker: arithmetic reference model with a per-cycle compare on the LAT_CYC=1
// instance, plus pipelined-adder instances at LAT_CYC=2 and 3.
module tb_rca4_sweep_checker;

`ifdef SWEEP_FIRST_ERR_EN
    localparam int FE_ON = 1;
`else
    localparam int FE_ON = 0;
`endif

    logic clk;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    // Instance 1: LAT_CYC=1, combinational adder with selectable fault.
    logic        rst1, start1;
    logic [3:0]  a1, b1, s1;
    logic        c1, co1, busy1, done1, fval1;
    logic [9:0]  ec1;
    logic [13:0] sed1;
    logic [4:0]  mx1;
    logic [8:0]  fv1;
    int          mode;
    logic [4:0]  mask [512];

    // Instances 2 and 3: exact adder behind two register stages.
    logic        rst23, start23;
    logic [3:0]  a2, b2, s2, a3, b3, s3;
    logic        c2, co2, busy2, done2, fval2, c3, co3, busy3, done3, fval3;
    logic [9:0]  ec2, ec3;
    logic [13:0] sed2, sed3;
    logic [4:0]  mx2, mx3, p1_2, p2_2, p1_3, p2_3;
    logic [8:0]  fv2, fv3;

    rca4_sweep_checker #(.LAT_CYC(1)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .A_out(a1), .B_out(b1), .Cin_out(c1),
        .dut_sum(s1), .dut_cout(co1), .busy(busy1), .done(done1), .err_cnt(ec1), .sed(sed1),
        .max_ed(mx1), .first_err_vec(fv1), .first_err_valid(fval1)
    );
    rca4_sweep_checker #(.LAT_CYC(2)) u2 (
        .clk(clk), .rst(rst23), .start(start23), .A_out(a2), .B_out(b2), .Cin_out(c2),
        .dut_sum(s2), .dut_cout(co2), .busy(busy2), .done(done2), .err_cnt(ec2), .sed(sed2),
        .max_ed(mx2), .first_err_vec(fv2), .first_err_valid(fval2)
    );
    rca4_sweep_checker #(.LAT_CYC(3)) u3 (
        .clk(clk), .rst(rst23), .start(start23), .A_out(a3), .B_out(b3), .Cin_out(c3),
        .dut_sum(s3), .dut_cout(co3), .busy(busy3), .done(done3), .err_cnt(ec3), .sed(sed3),
        .max_ed(mx3), .first_err_vec(fv3), .first_err_valid(fval3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        logic [4:0] e;
        logic [4:0] r;
        e = {1'b0, a1} + {1'b0, b1} + {4'b0000, c1};
        r = e;
        case (mode)
            1:       r = 5'd0;
            2:       r = e ^ 5'h10;
            3:       r = e ^ mask[{a1, b1, c1}];
            default: r = e;
        endcase
        {co1, s1} = r;
    end

    always @(posedge clk) begin
        p1_2 <= {1'b0, a2} + {1'b0, b2} + {4'b0000, c2};
        p2_2 <= p1_2;
        p1_3 <= {1'b0, a3} + {1'b0, b3} + {4'b0000, c3};
        p2_3 <= p1_3;
    end
    assign {co2, s2} = p2_2;
    assign {co3, s3} = p2_3;

    // Reference: metrics after the first k vectors of a sweep, k = 0..512.
    int pc [513];
    int ps [513];
    int pm [513];
    int pfv [513];
    int pfval [513];

    function automatic int model_val(int md, int v);
        int e;
        e = ((v >> 5) & 15) + ((v >> 1) & 15) + (v & 1);
        case (md)
            1:       return 0;
            2:       return e ^ 16;
            3:       return e ^ int'(mask[v]);
            default: return e;
        endcase
    endfunction

    task automatic build_model(input int md);
        pc[0] = 0; ps[0] = 0; pm[0] = 0; pfv[0] = 0; pfval[0] = 0;
        for (int k = 0; k < 512; k++) begin
            int e, d;
            e = ((k >> 5) & 15) + ((k >> 1) & 15) + (k & 1);
            d = e - model_val(md, k);
            if (d < 0) d = -d;
            pc[k+1] = pc[k] + ((d != 0) ? 1 : 0);
            ps[k+1] = ps[k] + d;
            pm[k+1] = (d > pm[k]) ? d : pm[k];
            pfval[k+1] = pfval[k];
            pfv[k+1] = pfv[k];
            if (d != 0 && pfval[k] == 0) begin
                pfval[k+1] = FE_ON;
                pfv[k+1] = FE_ON * k;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model of instance 1 sweep progress: t = edges since the accepted start, -1 when idle.
    int t;
    bit have;
    bit chk_en;
    initial begin
        t = -1;
        have = 0;
        chk_en = 0;
        forever begin
            @(posedge clk);
            if (rst1) begin
                t = -1;
                have = 0;
                chk_en = 1;
            end else if (t < 0) begin
                if (start1) begin
                    t = 0;
                    have = 1;
                end
            end else if (t >= 512) begin
                t = -1;
            end else begin
                t = t + 1;
            end
        end
    end

    initial begin : cmp
        int eb, edn, ev, n;
        int h_c, h_s, h_m, h_fv, h_fval;
        h_c = 0; h_s = 0; h_m = 0; h_fv = 0; h_fval = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (t == 512) begin
                    h_c = pc[512]; h_s = ps[512]; h_m = pm[512]; h_fv = pfv[512]; h_fval = pfval[512];
                end
                if (t < 0) begin
                    eb = 0; edn = 0; ev = have ? 511 : 0; n = -1;
                end else if (t < 512) begin
                    eb = 1; edn = 0; ev = t; n = t;
                end else begin
                    eb = 0; edn = 1; ev = 511; n = 512;
                end
                chk("cyc_busy", busy1, eb);
                chk("cyc_done", done1, edn);
                chk("cyc_vector", {a1, b1, c1}, ev);
                if (n >= 0) begin
                    chk("cyc_err_cnt", ec1, pc[n]);
                    chk("cyc_sed", sed1, ps[n]);
                    chk("cyc_max_ed", mx1, pm[n]);
                    chk("cyc_first_vec", fv1, pfv[n]);
                    chk("cyc_first_valid", fval1, pfval[n]);
                end else if (have) begin
                    chk("hold_err_cnt", ec1, h_c);
                    chk("hold_sed", sed1, h_s);
                    chk("hold_max_ed", mx1, h_m);
                    chk("hold_first_vec", fv1, h_fv);
                    chk("hold_first_valid", fval1, h_fval);
                end else begin
                    chk("zero_err_cnt", ec1, 0);
                    chk("zero_sed", sed1, 0);
                    chk("zero_max_ed", mx1, 0);
                    chk("zero_first_vec", fv1, 0);
                    chk("zero_first_valid", fval1, 0);
                end
            end
        end
    end

    // One sweep on instance 1; optionally re-pulses start at loop step mid. Ends idle, one cycle after done.
    task automatic sweep(input int md, input int mid, output int dedge);
        int acc;
        mode = md;
        build_model(md);
        @(negedge clk);
        start1 = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        start1 = 1'b0;
        dedge = -1;
        for (int i = 0; i < 700; i++) begin
            if (done1) begin
                dedge = cyc - acc;
                break;
            end
            if (i == mid) start1 = 1'b1;
            else start1 = 1'b0;
            @(negedge clk);
        end
        start1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vec"}, {a1, b1, c1}, 0);
        chk({tag, "_busy"}, busy1, 0);
        chk({tag, "_done"}, done1, 0);
        chk({tag, "_err_cnt"}, ec1, 0);
        chk({tag, "_sed"}, sed1, 0);
        chk({tag, "_max_ed"}, mx1, 0);
        chk({tag, "_first_vec"}, fv1, 0);
        chk({tag, "_first_valid"}, fval1, 0);
    endtask

    initial begin
        int de, acc, gap, d2, d3, e2, e3;
        mode = 0;
        rst1 = 1'b1; start1 = 1'b0;
        rst23 = 1'b1; start23 = 1'b0;
        for (int v = 0; v < 512; v++) begin
            mask[v] = ($urandom_range(3) == 0) ? 5'($urandom_range(31, 1)) : 5'd0;
        end
        build_model(0);
        repeat (3) @(negedge clk);
        rst1 = 1'b0;
        rst23 = 1'b0;
        chk_all_zero("reset");

        // Exact adder: clean sweep, done on edge 512.
        sweep(0, -1, de);
        chk("exact_done_edge", de, 512);
        chk("exact_err_cnt", ec1, 0);
        chk("exact_sed", sed1, 0);
        chk("exact_max_ed", mx1, 0);
        chk("exact_first_valid", fval1, 0);

        // Outputs tied to zero.
        sweep(1, -1, de);
        chk("zero_done_edge", de, 512);
        chk("zero_dut_err_cnt", ec1, 511);
        chk("zero_dut_sed", sed1, 7936);
        chk("zero_dut_max_ed", mx1, 31);
        chk("zero_dut_first_vec", fv1, FE_ON);
        chk("zero_dut_first_valid", fval1, FE_ON);

        // Cout inverted.
        sweep(2, -1, de);
        chk("cinv_err_cnt", ec1, 512);
        chk("cinv_sed", sed1, 8192);
        chk("cinv_max_ed", mx1, 16);
        chk("cinv_first_vec", fv1, 0);
        chk("cinv_first_valid", fval1, FE_ON);

        // Reset 100 cycles into a sweep, then a clean sweep.
        mode = 0;
        build_model(0);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (99) @(negedge clk);
        chk("pre_rst_busy", busy1, 1);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        chk_all_zero("mid_rst");
        sweep(0, -1, de);
        chk("post_rst_done_edge", de, 512);
        chk("post_rst_err_cnt", ec1, 0);
        chk("post_rst_sed", sed1, 0);

        // Random faults with a stray start pulse mid-sweep.
        sweep(3, 50, de);
        chk("rand_done_edge", de, 512);
        chk("rand_err_cnt", ec1, pc[512]);
        chk("rand_sed", sed1, ps[512]);
        chk("rand_max_ed", mx1, pm[512]);
        chk("rand_first_vec", fv1, pfv[512]);

        // start held high: back-to-back sweeps.
        mode = 1;
        build_model(1);
        @(negedge clk);
        start1 = 1'b1;
        acc = cyc + 1;
        de = -1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (done1) begin
                de = cyc - acc;
                break;
            end
        end
        chk("b2b_first_done_edge", de, 512);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            gap++;
            if (busy1) break;
        end
        chk("b2b_restart_gap", gap, 2);
        chk("b2b_cleared_err_cnt", ec1, 0);
        acc = cyc;
        de = -1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (done1) begin
                de = cyc - acc;
                break;
            end
        end
        start1 = 1'b0;
        chk("b2b_second_done_edge", de, 512);
        chk("b2b_second_err_cnt", ec1, 511);
        repeat (3) @(negedge clk);

        // Pipelined adder: LAT_CYC=3 is clean, LAT_CYC=2 samples too early.
        @(negedge clk);
        start23 = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        start23 = 1'b0;
        d2 = -1; d3 = -1; e2 = 0; e3 = -1;
        for (int i = 0; i < 1700; i++) begin
            if (done2 && d2 < 0) begin
                d2 = cyc - acc;
                e2 = int'(ec2);
            end
            if (done3 && d3 < 0) begin
                d3 = cyc - acc;
                e3 = int'(ec3);
                break;
            end
            @(negedge clk);
        end
        chk("lat3_done_edge", d3, 1536);
        chk("lat3_err_cnt", e3, 0);
        chk("lat2_done_edge", d2, 1024);
        chk("lat2_err_nonzero", (e2 > 0) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
